main_mem_responder: RTL and testbench

Synthesizable main-memory responder: the target end of the cache controller's main-memory request/ready handshake. It accepts single-word write requests and 64-byte line-fill read requests. It holds 16 KB of word storage and answers each request after a programmable access latency with a one-cycle `main_mem_ready` pulse. It sits directly behind the cache controller's `main_mem_*` ports and replaces the behavioural memory model in system-level simulation and FPGA builds.

---
 rtl/mm_pkg.sv | 26 ++
 rtl/mm_word_ram.sv | 32 +++
 rtl/main_mem_responder.sv | 147 ++++++++++++++
 tb/tb_main_mem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mm_pkg
//  Description : Shared types and constants for the main-memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
package mm_pkg;

    // Responder FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } mm_state_t;

    localparam int LINE_BITS      = 512;
    localparam int WORD_BITS      = 32;
    localparam int WORDS_PER_LINE = 16;

    // Beat counter must reach WORDS_PER_LINE (one extra beat drains the RAM pipeline)
    localparam int BEAT_W = 5;

endpackage : mm_pkg
`default_nettype wire

// File: rtl/mm_word_ram.sv
`default_nettype none
// ============================================================================
//  Module      : mm_word_ram
//  Description : Single-port synchronous word RAM, WORDS x 32, read-first.
//                Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module mm_word_ram
    import mm_pkg::*;
#(
    parameter int WORDS  = 4096,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] r_mem [WORDS];

    // Synchronous write and registered read of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule : mm_word_ram
`default_nettype wire

// File: rtl/main_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : main_mem_responder
//  Description : Target side of the cache controller main-memory handshake.
//                Single-word writes and 64-byte line-fill reads, answered
//                after a programmable latency with a one-cycle ready pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module main_mem_responder
    import mm_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int WORDS   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          main_mem_addr,
    input  logic [31:0]          main_mem_data_out,
    input  logic                 main_mem_read_req,
    input  logic                 main_mem_write_req,
    output logic [LINE_BITS-1:0] main_mem_data_in,
    output logic                 main_mem_ready,
    output logic                 mem_busy
);

    localparam int              ADDR_W     = $clog2(WORDS);
    localparam logic [7:0]      c_LAT_LAST = 8'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] c_BEAT_LAST = BEAT_W'(WORDS_PER_LINE);

    mm_state_t             r_state;
    mm_state_t             w_next_state;
    logic [7:0]            r_lat_cnt;
    logic [BEAT_W-1:0]     r_beat;
    logic [ADDR_W-1:0]     r_word_addr;
    logic [WORD_BITS-1:0]  r_wdata;
    logic                  r_is_read;
    logic [LINE_BITS-1:0]  r_line;
    logic                  r_ready;
    logic                  r_busy;

    logic                  w_req;
    logic                  w_ram_we;
    logic [ADDR_W-1:0]     w_ram_addr;
    logic [WORD_BITS-1:0]  w_ram_rdata;
    logic [3:0]            w_cap_idx;
    logic                  w_unused_addr_bits;

    // Only the word-index bits of the address matter; the rest wrap / are ignored
    assign w_unused_addr_bits = ^{main_mem_addr[31:ADDR_W+2], main_mem_addr[1:0]};

    assign w_req    = main_mem_read_req | main_mem_write_req;
    assign w_ram_we = (r_state == ST_WRITE);

    // Writes use the full word index; reads walk the line with the beat counter
    assign w_ram_addr = w_ram_we ? r_word_addr
                                 : {r_word_addr[ADDR_W-1:4], r_beat[3:0]};

    // RAM data returns one beat late, so beat b fills word b-1 (beat 16 fills word 15)
    assign w_cap_idx = r_beat[3:0] - 4'd1;

    mm_word_ram #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_req) w_next_state = ST_WAIT;
            ST_WAIT:  if (r_lat_cnt == c_LAT_LAST)
                          w_next_state = r_is_read ? ST_READ : ST_WRITE;
            ST_READ:  if (r_beat == c_BEAT_LAST) w_next_state = ST_DONE;
            ST_WRITE: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Request latches, latency / beat counters and line assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt   <= '0;
            r_beat      <= '0;
            r_word_addr <= '0;
            r_wdata     <= '0;
            r_is_read   <= 1'b0;
            r_line      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_is_read   <= main_mem_read_req;
                        r_word_addr <= main_mem_addr[ADDR_W+1:2];
                        if (!main_mem_read_req) begin
                            r_wdata <= main_mem_data_out;
                        end
                        r_lat_cnt <= '0;
                        r_beat    <= '0;
                    end
                end
                ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + 8'd1;
                end
                ST_READ: begin
                    r_beat <= r_beat + BEAT_W'(1);
                    if (r_beat != '0) begin
                        r_line[{w_cap_idx, 5'd0} +: WORD_BITS] <= w_ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered handshake outputs, derived from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= (w_next_state == ST_DONE);
            r_busy  <= (w_next_state != ST_IDLE);
        end
    end

    assign main_mem_data_in = r_line;
    assign main_mem_ready   = r_ready;
    assign mem_busy         = r_busy;

endmodule : main_mem_responder
`default_nettype wire

// File: tb/tb_main_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_mem_responder
//  Description : Scoreboard bench for main_mem_responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_main_mem_responder;

    localparam int LAT = 4;

    logic         clk;
    logic         rst_n;
    logic [31:0]  main_mem_addr;
    logic [31:0]  main_mem_data_out;
    logic         main_mem_read_req;
    logic         main_mem_write_req;
    logic [511:0] main_mem_data_in;
    logic         main_mem_ready;
    logic         mem_busy;

    typedef struct {
        logic         is_read;
        int           due;
        logic [511:0] line;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    main_mem_responder #(.LATENCY(LAT), .WORDS(4096)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .main_mem_addr      (main_mem_addr),
        .main_mem_data_out  (main_mem_data_out),
        .main_mem_read_req  (main_mem_read_req),
        .main_mem_write_req (main_mem_write_req),
        .main_mem_data_in   (main_mem_data_in),
        .main_mem_ready     (main_mem_ready),
        .mem_busy           (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ready pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && main_mem_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready: ready seen at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc != e.due) begin
                    bad++;
                    $display("FAIL %s_latency: ready at cycle %0d, required %0d", e.name, cyc, e.due);
                end
                if (e.is_read) begin
                    total++;
                    if (main_mem_data_in !== e.line) begin
                        bad++;
                        $display("FAIL %s_line: got %h required %h", e.name, main_mem_data_in, e.line);
                    end
                end
            end
        end
    end

    task automatic check1(input string name, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Issue one request once the responder is idle; queue its expected answer
    task automatic issue(input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [511:0] line);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (mem_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mem_busy) begin
            total++;
            bad++;
            $display("FAIL %s_idle_wait: busy=%0b after %0d cycles, required 0", name, mem_busy, n);
        end
        main_mem_addr      = a;
        main_mem_data_out  = d;
        main_mem_read_req  = rd;
        main_mem_write_req = wr;
        e.is_read = rd;
        e.due     = cyc + 1 + (rd ? LAT + 17 : LAT + 1);
        e.line    = line;
        e.name    = name;
        exp_q.push_back(e);
        @(negedge clk);
        main_mem_read_req  = 1'b0;
        main_mem_write_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: pending=%0d, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [511:0] all_f;
    logic [511:0] l_w2;
    logic [511:0] l_w0w2;

    initial begin
        all_f  = {16{32'hFFFF_FFFF}};
        l_w2   = all_f;
        l_w2[2*32 +: 32] = 32'h1234_5678;
        l_w0w2 = l_w2;
        l_w0w2[0 +: 32]  = 32'hCAFE_F00D;

        main_mem_addr      = '0;
        main_mem_data_out  = '0;
        main_mem_read_req  = 1'b0;
        main_mem_write_req = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4096; i++) dut.u_ram.r_mem[i] = 32'hFFFF_FFFF;

        // Reset asserted between clock edges
        #12 rst_n = 1'b0;
        #1;
        check1("rst_ready", 512'(main_mem_ready), 512'd0);
        check1("rst_busy",  512'(mem_busy),       512'd0);
        check1("rst_line",  main_mem_data_in,     512'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write then line read
        issue("w48", 1'b0, 1'b1, 32'h0000_0048, 32'h1234_5678, '0);
        drain("w48");
        issue("r40", 1'b1, 1'b0, 32'h0000_0040, 32'h0, l_w2);
        drain("r40");

        // Simultaneous requests: read wins, write dropped
        issue("both80", 1'b1, 1'b1, 32'h0000_0080, 32'h55AA_55AA, all_f);
        drain("both80");
        issue("r80", 1'b1, 1'b0, 32'h0000_0080, 32'h0, all_f);
        drain("r80");

        // Write pulse while busy is ignored
        issue("r0a", 1'b1, 1'b0, 32'h0000_0000, 32'h0, all_f);
        @(negedge clk);
        main_mem_addr      = 32'h0;
        main_mem_data_out  = 32'h1111_1111;
        main_mem_write_req = 1'b1;
        @(negedge clk);
        main_mem_write_req = 1'b0;
        drain("r0a");
        issue("r0b", 1'b1, 1'b0, 32'h0000_0000, 32'h0, all_f);
        drain("r0b");

        // Address wrap modulo 16 KB
        issue("w4040", 1'b0, 1'b1, 32'h0000_4040, 32'hCAFE_F00D, '0);
        drain("w4040");
        issue("rwrap", 1'b1, 1'b0, 32'h0000_0040, 32'h0, l_w0w2);
        drain("rwrap");

        // Reset during WAIT discards the pending write
        issue("w100", 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, '0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check1("midrst_ready", 512'(main_mem_ready), 512'd0);
        check1("midrst_busy",  512'(mem_busy),       512'd0);
        check1("midrst_line",  main_mem_data_in,     512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("r100", 1'b1, 1'b0, 32'h0000_0100, 32'h0, all_f);
        drain("r100");

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_main_mem_responder
`default_nettype wire
